counter_2bit_fsm: RTL and testbench

// - 2-bit event counter built as a 4-state Moore FSM.
// - Each clock edge that samples input x high advances the state by one.
// - The state wraps S3 -> S0.
// - The current state is driven directly on the output.
// - Standalone lab block: counts pulses on a qualified event line and

---
 rtl/counter_2bit_fsm.sv | 45 ++++
 tb/tb_counter_2bit_fsm.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/counter_2bit_fsm.sv
// 2-bit event counter as a 4-state Moore FSM: each clock edge that samples
// x high advances the state by one, wrapping S3 -> S0.
module counter_2bit_fsm #(
  parameter logic [1:0] RESET_STATE = 2'b00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       x,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } state_t;

  state_t state_q;
  state_t state_d;

  // Next-state: x is level-sampled; an unknown encoding falls back to S0.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S0:      state_d = x ? S1 : S0;
      S1:      state_d = x ? S2 : S1;
      S2:      state_d = x ? S3 : S2;
      S3:      state_d = x ? S0 : S3;
      default: state_d = S0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= state_t'(RESET_STATE);
    end else begin
      state_q <= state_d;
    end
  end

  // Moore output straight from the register: no combinational path from x.
  assign state = state_q;

endmodule

// File: tb/tb_counter_2bit_fsm.sv
// Scoreboard bench for counter_2bit_fsm: directed and random stimulus against
// a modulo-4 event-count model, with two instances (reset state 00 and 11).
module tb_counter_2bit_fsm;

  typedef struct {
    logic [1:0] e0;
    logic [1:0] e1;
    string      tag;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       x;
  logic [1:0] state0;
  logic [1:0] state1;

  exp_t exp_q[$];
  int   chk_cnt;
  int   pass_cnt;

  // Model: number of counted events since the last reset, mod 4, offset by
  // the reset value.
  int   cnt0;
  int   cnt1;
  bit   known;

  counter_2bit_fsm #(.RESET_STATE(2'b00)) dut0 (
    .clk   (clk),
    .rst   (rst),
    .x     (x),
    .state (state0)
  );

  counter_2bit_fsm #(.RESET_STATE(2'b11)) dut1 (
    .clk   (clk),
    .rst   (rst),
    .x     (x),
    .state (state1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compare(input string name, input logic [1:0] act, input logic [1:0] req);
    chk_cnt++;
    if (act === req) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: state=%b required=%b at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle at the falling edge, push the expected post-edge state,
  // then wait for the rising edge. glitch=1 adds a 3 ns x pulse that ends
  // before the rising edge.
  task automatic step(input bit r, input bit xv, input bit glitch, input string tag);
    exp_t e;
    @(negedge clk);
    rst = r;
    x   = glitch ? 1'b0 : xv;
    if (r) begin
      cnt0  = 0;
      cnt1  = 0;
      known = 1'b1;
    end else if (known && x) begin
      cnt0 = cnt0 + 1;
      cnt1 = cnt1 + 1;
    end
    if (known) begin
      e.e0  = 2'((0 + cnt0) % 4);
      e.e1  = 2'((3 + cnt1) % 4);
      e.tag = tag;
      exp_q.push_back(e);
    end
    if (glitch) begin
      #1 x = 1'b1;
      #3 x = 1'b0;
    end
    @(posedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compare({e.tag, "/rs00"}, state0, e.e0);
        compare({e.tag, "/rs11"}, state1, e.e1);
      end
    end
  end

  initial begin : driver
    rst      = 1'b1;
    x        = 1'b0;
    chk_cnt  = 0;
    pass_cnt = 0;
    cnt0     = 0;
    cnt1     = 0;
    known    = 1'b0;

    step(1, 0, 0, "reset");
    step(1, 0, 0, "reset_hold");
    step(0, 0, 0, "idle");

    for (int p = 0; p < 4; p++) begin
      step(0, 1, 0, "pulse");
      step(0, 0, 0, "pulse_gap");
      step(0, 0, 0, "pulse_gap");
    end

    for (int i = 0; i < 6; i++) step(0, 1, 0, "held");

    // Reach 10 from the current count, then reset with x high.
    while ((cnt0 % 4) != 2) step(0, 1, 0, "seek10");
    step(1, 1, 0, "rst_beats_x");
    step(0, 1, 0, "post_rst_pulse");
    step(0, 0, 0, "post_rst_gap");
    step(0, 1, 0, "post_rst_pulse");
    step(0, 0, 0, "post_rst_gap");

    step(0, 0, 1, "glitch");
    step(0, 0, 1, "glitch");
    step(0, 0, 0, "after_glitch");

    step(1, 0, 0, "param_reset");
    step(0, 1, 0, "param_pulse");

    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 15) == 0), $urandom_range(0, 1), ($urandom_range(0, 7) == 0), "random");
    end

    step(0, 0, 0, "drain");
    #2;
    chk_cnt++;
    if (exp_q.size() == 0) begin
      pass_cnt++;
    end else begin
      $display("FAIL scoreboard_drain: pending=%0d required=0", exp_q.size());
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
